// File: rtl/ci_response_collector.sv
// ci_response_collector
//   Merges the done/result pairs of NR_OF_SLAVES custom-instruction slaves into a
//   single registered response for the CPU CI port. Only one CI may be outstanding;
//   an optional cycle watchdog ends a CI that no slave answers. Protocol errors are
//   latched in a sticky status word, which is read through this block's own CI number.
//
// Ports
//   clock      : system clock, all state on rising edge
//   reset      : asynchronous, active-low reset
//   ciStart    : CPU CI start strobe
//   ciCke      : CPU CI clock enable (low = stall)
//   ciN        : CI number of the started instruction
//   ciValueB   : operand B; bit 0 requests clear-on-read for the status CI
//   slvDone    : done strobes from the slaves
//   slvResult  : slave results, slave k on bits [32k+31:32k]
//   ciDone     : registered one-cycle done pulse to the CPU
//   ciResult   : registered result, 0 whenever ciDone is 0
//   errorFlag  : OR of sticky status bits [3:0]
//
// Status word: [0] timeout, [1] multi-done, [2] spurious done, [3] start-while-busy,
//              [7:4] 0, [15:8] ciN of last timeout, [31:16] saturating error-event count.
module ci_response_collector #(
  parameter int unsigned NR_OF_SLAVES        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES      = 32'd0,
  parameter logic [31:0] ERROR_RESULT        = 32'hDEADDEAD,
  parameter logic [7:0]  customInstructionId = 8'd255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ciStart,
  input  logic                         ciCke,
  input  logic [7:0]                   ciN,
  input  logic [31:0]                  ciValueB,
  input  logic [NR_OF_SLAVES-1:0]      slvDone,
  input  logic [32*NR_OF_SLAVES-1:0]   slvResult,
  output logic                         ciDone,
  output logic [31:0]                  ciResult,
  output logic                         errorFlag
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STAT, S_RESP} state_t;

  state_t      state;
  logic [31:0] watchdog;
  logic [31:0] status;
  logic [31:0] statusNext;
  logic [31:0] mergedResult;
  logic [7:0]  ciNLatched;
  logic        clearOnRead;

  logic act, startStatus, startSlave, anyDone, sampleDone;
  logic evTimeout, evMulti, evSpurious, evBusy, evAny, clearNow;
  logic unusedValueB;

  assign unusedValueB = ^ciValueB[31:1];

  assign act         = ciStart & ciCke;
  assign startStatus = act & (ciN == customInstructionId);
  assign startSlave  = act & (ciN != customInstructionId);
  assign anyDone     = |slvDone;

  // The start cycle of a slave CI is sampled like a WAIT cycle, so a combinational
  // slave answering in the start cycle completes the CI immediately.
  assign sampleDone = anyDone & (((state == S_IDLE) & startSlave) | ((state == S_WAIT) & ciCke));

  assign evMulti    = sampleDone & ($countones(slvDone) > 1);
  assign evSpurious = (state == S_IDLE) & anyDone & ~act;
  assign evBusy     = (state == S_WAIT) & act;
  // A done in the expiry cycle wins, so the timeout needs an empty done vector.
  assign evTimeout  = (state == S_WAIT) & ciCke & ~anyDone & (watchdog == 32'd1);
  assign evAny      = evMulti | evSpurious | evBusy | evTimeout;
  assign clearNow   = (state == S_STAT) & ciCke & clearOnRead;

  assign errorFlag = |status[3:0];

  always_comb begin
    mergedResult = '0;
    for (int unsigned k = 0; k < NR_OF_SLAVES; k++) begin
      if (slvDone[k]) mergedResult = mergedResult | slvResult[32*k +: 32];
    end
  end

  always_comb begin
    statusNext = status;
    if (clearNow) begin
      statusNext = '0;
    end else if (evAny) begin
      statusNext[0] = status[0] | evTimeout;
      statusNext[1] = status[1] | evMulti;
      statusNext[2] = status[2] | evSpurious;
      statusNext[3] = status[3] | evBusy;
      if (evTimeout) statusNext[15:8] = ciNLatched;
      if (status[31:16] != 16'hFFFF) statusNext[31:16] = status[31:16] + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      watchdog    <= '0;
      status      <= '0;
      ciNLatched  <= '0;
      clearOnRead <= 1'b0;
      ciDone      <= 1'b0;
      ciResult    <= '0;
    end else begin
      status   <= statusNext;
      // The response is a single-cycle pulse even if ciCke is low.
      ciDone   <= 1'b0;
      ciResult <= '0;
      if (ciCke) begin
        unique case (state)
          S_IDLE: begin
            if (startStatus) begin
              state       <= S_STAT;
              clearOnRead <= ciValueB[0];
            end else if (startSlave) begin
              ciNLatched <= ciN;
              if (anyDone) begin
                state    <= S_RESP;
                ciDone   <= 1'b1;
                ciResult <= mergedResult;
              end else begin
                state    <= S_WAIT;
                watchdog <= TIMEOUT_CYCLES;
              end
            end
          end
          S_WAIT: begin
            if (anyDone) begin
              state    <= S_RESP;
              ciDone   <= 1'b1;
              ciResult <= mergedResult;
            end else if (watchdog != 32'd0) begin
              watchdog <= watchdog - 32'd1;
              if (watchdog == 32'd1) begin
                state    <= S_RESP;
                ciDone   <= 1'b1;
                ciResult <= ERROR_RESULT;
              end
            end
          end
          S_STAT: begin
            state    <= S_RESP;
            ciDone   <= 1'b1;
            ciResult <= status;
          end
          S_RESP: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
